// File: rtl/mat_io_pkg.sv
// Shared types and helpers for the Avalon-MM matrix I/O responder.
// Holds the FSM encoding, the CTRL/STATUS address derivation and the byte-lane merge.
package mat_io_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;
   localparam int STATUS_ERR_BIT  = 2;

   // CTRL and STATUS sit directly after the four operand planes.
   function automatic int ctrl_offset(input int n);
      return 4 * n * n;
   endfunction

   function automatic int status_offset(input int n);
      return 4 * n * n + 1;
   endfunction

   function automatic logic [63:0] byte_merge(input logic [63:0] old_w,
                                              input logic [63:0] new_w,
                                              input logic [7:0]  be);
      logic [63:0] r;
      r = old_w;
      for (int b = 0; b < 8; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/avmm_mat_io_slave_if.sv
// Avalon-MM host bus plus the operand/result streams to the element-wise core.
// Streams: a beat transfers on a rising clk edge where valid && ready; the source holds data stable while valid && !ready.
interface avmm_mat_io_slave_if #(
   parameter int ADDR_W = 23
);
   logic [ADDR_W-1:0] address;
   logic [63:0]       writedata;
   logic              write;
   logic              read;
   logic [7:0]        byteenable;
   logic [63:0]       readdata;
   logic              waitrequest;

   logic              op_valid;
   logic              op_ready;
   logic [63:0]       op_a_re;
   logic [63:0]       op_a_im;
   logic [63:0]       op_b_re;
   logic [63:0]       op_b_im;

   logic              res_valid;
   logic              res_ready;
   logic [63:0]       res_re;
   logic [63:0]       res_im;

   modport slave (
      input  address, writedata, write, read, byteenable,
      output readdata, waitrequest,
      output op_valid, op_a_re, op_a_im, op_b_re, op_b_im,
      input  op_ready,
      input  res_valid, res_re, res_im,
      output res_ready
   );

   modport master (
      output address, writedata, write, read, byteenable,
      input  readdata, waitrequest,
      input  op_valid, op_a_re, op_a_im, op_b_re, op_b_im,
      output op_ready,
      output res_valid, res_re, res_im,
      input  res_ready
   );
endinterface

// File: rtl/mat_io_regfile.sv
// Operand planes (byte-merged writes, combinational element read) and result store
// with a registered host read port.
module mat_io_regfile
   import mat_io_pkg::*;
#(
   parameter int E  = 4,
   parameter int CW = 3,
   parameter int OW = 4,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_op_we,
   input  logic [OW-1:0] i_op_idx,
   input  logic [63:0]   i_op_wdata,
   input  logic [7:0]    i_op_be,
   input  logic [CW-1:0] i_issue_idx,
   output logic [63:0]   o_a_re,
   output logic [63:0]   o_a_im,
   output logic [63:0]   o_b_re,
   output logic [63:0]   o_b_im,
   input  logic          i_res_we,
   input  logic [CW-1:0] i_res_idx,
   input  logic [63:0]   i_res_re,
   input  logic [63:0]   i_res_im,
   input  logic          i_rd_en,
   input  logic          i_rd_res,
   input  logic [RW-1:0] i_rd_idx,
   input  logic [63:0]   i_rd_alt,
   output logic [63:0]   o_rdata
);

   logic [63:0]   r_op  [4*E];
   logic [63:0]   r_res [2*E];
   logic [OW-1:0] w_op_base;
   logic [RW-1:0] w_res_base;

   // Once issue_cnt reaches E the index is parked at 0 to stay inside the array.
   always_comb begin
      w_op_base  = (i_issue_idx < CW'(E)) ? OW'(i_issue_idx) : '0;
      w_res_base = RW'(i_res_idx);
      o_a_re     = r_op[w_op_base];
      o_a_im     = r_op[w_op_base + OW'(E)];
      o_b_re     = r_op[w_op_base + OW'(2*E)];
      o_b_im     = r_op[w_op_base + OW'(3*E)];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4*E; i++) r_op[i] <= '0;
      end else if (i_op_we) begin
         r_op[i_op_idx] <= byte_merge(r_op[i_op_idx], i_op_wdata, i_op_be);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2*E; i++) r_res[i] <= '0;
      end else if (i_res_we) begin
         r_res[w_res_base]          <= i_res_re;
         r_res[w_res_base + RW'(E)] <= i_res_im;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_rdata <= '0;
      end else if (i_rd_en) begin
         o_rdata <= i_rd_res ? r_res[i_rd_idx] : i_rd_alt;
      end
   end

endmodule

// File: rtl/avmm_mat_io_slave.sv
// Avalon-MM responder: decodes host accesses, runs the IDLE/RUN/DONE sequencer
// that streams operands to the core and captures its in-order results.
module avmm_mat_io_slave
   import mat_io_pkg::*;
#(
   parameter int mat_num_row = 2,
   parameter int ADDR_W      = 23
) (
   input  logic                      clk,
   input  logic                      reset,
   avmm_mat_io_slave_if.slave        io_bus,
   output state_t                    o_state
);

   localparam int E  = mat_num_row * mat_num_row;
   localparam int CW = $clog2(E + 1);
   localparam int OW = $clog2(4 * E);
   localparam int RW = $clog2(2 * E);
   localparam logic [ADDR_W-1:0] OP_END    = ADDR_W'(4 * E);
   localparam logic [ADDR_W-1:0] RES_END   = ADDR_W'(2 * E);
   localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_offset(mat_num_row));
   localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(status_offset(mat_num_row));
   localparam logic [CW-1:0]     E_CNT     = CW'(E);
   localparam logic [CW-1:0]     E_LAST    = CW'(E - 1);

   state_t        r_state;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic [CW-1:0] r_issue_cnt;
   logic [CW-1:0] r_res_cnt;

   logic          w_is_op;
   logic          w_is_res;
   logic          w_is_ctrl;
   logic          w_is_stat;
   logic          w_wr_acc;
   logic          w_rd_acc;
   logic          w_op_fire;
   logic          w_res_fire;
   logic [63:0]   w_status;
   logic [63:0]   w_rd_alt;

   assign w_is_op   = io_bus.address < OP_END;
   assign w_is_res  = io_bus.address < RES_END;
   assign w_is_ctrl = io_bus.address == CTRL_ADDR;
   assign w_is_stat = io_bus.address == STAT_ADDR;

   // Only operand writes stall; a colliding read is dropped in favour of the write.
   assign io_bus.waitrequest = ~reset | (io_bus.write & w_is_op & r_busy);
   assign w_wr_acc           = io_bus.write & ~io_bus.waitrequest;
   assign w_rd_acc           = io_bus.read & ~io_bus.write;

   assign io_bus.op_valid  = (r_state == ST_RUN) && (r_issue_cnt < E_CNT);
   assign io_bus.res_ready = (r_state == ST_RUN) && (r_res_cnt < E_CNT);
   assign w_op_fire        = io_bus.op_valid & io_bus.op_ready;
   assign w_res_fire       = io_bus.res_valid & io_bus.res_ready;
   assign o_state          = r_state;

   always_comb begin
      w_status                  = '0;
      w_status[STATUS_BUSY_BIT] = r_busy;
      w_status[STATUS_DONE_BIT] = r_done;
      w_status[STATUS_ERR_BIT]  = r_err;
      w_rd_alt                  = w_is_stat ? w_status : 64'd0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_issue_cnt <= '0;
         r_res_cnt   <= '0;
      end else begin
         if (w_wr_acc && w_is_stat) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
         end
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_wr_acc && w_is_ctrl) begin
                  r_state     <= ST_RUN;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_issue_cnt <= '0;
                  r_res_cnt   <= '0;
               end
            end
            ST_RUN: begin
               if (w_wr_acc && w_is_ctrl) r_err <= 1'b1;
               if (w_op_fire) r_issue_cnt <= r_issue_cnt + 1'b1;
               if (w_res_fire) begin
                  r_res_cnt <= r_res_cnt + 1'b1;
                  if (r_res_cnt == E_LAST) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   mat_io_regfile #(
      .E  (E),
      .CW (CW),
      .OW (OW),
      .RW (RW)
   ) u_regfile (
      .clk         (clk),
      .reset       (reset),
      .i_op_we     (w_wr_acc & w_is_op),
      .i_op_idx    (OW'(io_bus.address)),
      .i_op_wdata  (io_bus.writedata),
      .i_op_be     (io_bus.byteenable),
      .i_issue_idx (r_issue_cnt),
      .o_a_re      (io_bus.op_a_re),
      .o_a_im      (io_bus.op_a_im),
      .o_b_re      (io_bus.op_b_re),
      .o_b_im      (io_bus.op_b_im),
      .i_res_we    (w_res_fire),
      .i_res_idx   (r_res_cnt),
      .i_res_re    (io_bus.res_re),
      .i_res_im    (io_bus.res_im),
      .i_rd_en     (w_rd_acc),
      .i_rd_res    (w_is_res),
      .i_rd_idx    (RW'(io_bus.address)),
      .i_rd_alt    (w_rd_alt),
      .o_rdata     (io_bus.readdata)
   );

endmodule
